// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch front end: pipelined in-order word reads feeding a PC-tagged FIFO towards Fetch.
// Latency: a response reaches InstValid one cycle after MemReadDataValid.
// Backpressure: reads are credit-limited by queued plus in-flight words; Fetch stalls by holding InstReady low.

module pf_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          pop_fire;

  assign head_vld = (count != '0);
  assign pop_fire = pop_rdy & head_vld;
  assign head_dat = mem[rd_ptr];

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_vld) - (AW+1)'(pop_fire);
    end
  end
endmodule

module inst_prefetch_buffer #(
  parameter int                   WORD_SIZE = 16,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  output logic                 MemRead,
  output logic [WORD_SIZE-1:0] MemAddr,
  input  logic                 MemWaitreq,
  input  logic                 MemReadDataValid,
  input  logic [WORD_SIZE-1:0] MemReadData,
  input  logic                 Redirect,
  input  logic [WORD_SIZE-1:0] RedirectAddr,
  output logic                 InstValid,
  input  logic                 InstReady,
  output logic [WORD_SIZE-1:0] InstOut,
  output logic [WORD_SIZE-1:0] InstPC
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state;
  logic [WORD_SIZE-1:0]   fetch_pc, resp_pc, fetch_pc_nxt;
  logic [CW-1:0]          outstanding, drop_cnt, fifo_count;
  logic [CW-1:0]          out_nxt, fifo_nxt, drop_nxt;
  logic [CW:0]            credit_sum;
  logic                   accept, push, pop, hold, stale, credit_ok, head_vld;
  logic [2*WORD_SIZE-1:0] head_dat;

  assign accept    = MemRead & ~MemWaitreq;
  assign hold      = (state == REQ) & ~accept;
  assign push      = MemReadDataValid & (drop_cnt == '0) & ~Redirect;
  assign InstValid = head_vld & ~Redirect;
  assign pop       = InstValid & InstReady;
  assign {InstOut, InstPC} = head_dat;

  pf_fifo #(.W(2*WORD_SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk      (Clock),
    .rst_n    (Reset_n),
    .flush    (Redirect),
    .push_vld (push),
    .push_dat ({MemReadData, resp_pc}),
    .pop_rdy  (pop),
    .head_vld (head_vld),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

  // Credit is judged on next-cycle occupancy so a freed slot is reissued immediately.
  // A request held across a Redirect (stale) fetches old data: it must not advance
  // fetch_pc and its response joins the drop count once accepted.
  always_comb begin
    out_nxt    = outstanding + CW'(accept) - CW'(MemReadDataValid);
    fifo_nxt   = Redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
    credit_sum = {1'b0, fifo_nxt} + {1'b0, out_nxt};
    credit_ok  = credit_sum < (CW+1)'(DEPTH);
    if (Redirect)
      drop_nxt = out_nxt;
    else
      drop_nxt = drop_cnt - CW'(MemReadDataValid && drop_cnt != '0) + CW'(accept && stale);
    if (Redirect)
      fetch_pc_nxt = RedirectAddr;
    else if (accept && !stale)
      fetch_pc_nxt = fetch_pc + 1'b1;
    else
      fetch_pc_nxt = fetch_pc;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      MemRead     <= 1'b0;
      MemAddr     <= RESET_PC;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      stale       <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      fetch_pc    <= fetch_pc_nxt;
      stale       <= Redirect ? hold : (stale & ~accept);
      if (Redirect)
        resp_pc <= RedirectAddr;
      else if (push)
        resp_pc <= resp_pc + 1'b1;
      if (!hold) begin
        if (credit_ok) begin
          state   <= REQ;
          MemRead <= 1'b1;
          MemAddr <= fetch_pc_nxt;
        end else begin
          state   <= IDLE;
          MemRead <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer: memory model with 1- or 2-cycle latency returning addr ^ 0xA5A5.
module tb_inst_prefetch_buffer;
  logic        Clock;
  logic        Reset_n;
  logic        MemRead;
  logic [15:0] MemAddr;
  logic        MemWaitreq;
  logic        MemReadDataValid;
  logic [15:0] MemReadData;
  logic        Redirect;
  logic [15:0] RedirectAddr;
  logic        InstValid;
  logic        InstReady;
  logic [15:0] InstOut;
  logic [15:0] InstPC;

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  int acc_cnt;
  logic        s_vld [2];
  logic [15:0] s_dat [2];

  inst_prefetch_buffer #(.WORD_SIZE(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .MemRead          (MemRead),
    .MemAddr          (MemAddr),
    .MemWaitreq       (MemWaitreq),
    .MemReadDataValid (MemReadDataValid),
    .MemReadData      (MemReadData),
    .Redirect         (Redirect),
    .RedirectAddr     (RedirectAddr),
    .InstValid        (InstValid),
    .InstReady        (InstReady),
    .InstOut          (InstOut),
    .InstPC           (InstPC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: samples the request mid-cycle, answers lat cycles after acceptance.
  always @(negedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s_vld[0] = 1'b0; s_vld[1] = 1'b0;
      s_dat[0] = '0;   s_dat[1] = '0;
      MemReadDataValid = 1'b0;
      MemReadData = '0;
      acc_cnt = 0;
    end else begin
      MemReadDataValid = (lat == 2) ? s_vld[1] : s_vld[0];
      MemReadData      = (lat == 2) ? s_dat[1] : s_dat[0];
      s_vld[1] = s_vld[0];
      s_dat[1] = s_dat[0];
      s_vld[0] = MemRead && !MemWaitreq;
      s_dat[0] = MemAddr ^ 16'hA5A5;
      if (s_vld[0]) acc_cnt++;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 ({tag, "_memread"}, MemRead,   1'b0);
    chk16({tag, "_memaddr"}, MemAddr,   16'h0000);
    chk1 ({tag, "_valid"},   InstValid, 1'b0);
    chk16({tag, "_instout"}, InstOut,   16'h0000);
    chk16({tag, "_instpc"},  InstPC,    16'h0000);
  endtask

  initial begin
    Reset_n = 1'b1; Redirect = 1'b0; RedirectAddr = '0;
    MemWaitreq = 1'b0; InstReady = 1'b1;
    #2 Reset_n = 1'b0;
    #1 chk_reset_vals("rst");
    @(posedge Clock);
    @(posedge Clock);
    #1 Reset_n = 1'b1;

    // Streaming, 1-cycle memory, Fetch always ready
    tick(); chk1("s_rd0", MemRead, 1'b1); chk16("s_addr0", MemAddr, 16'h0000); chk1("s_v0", InstValid, 1'b0);
    tick(); chk16("s_addr1", MemAddr, 16'h0001); chk1("s_v1", InstValid, 1'b0);
    tick(); chk16("s_addr2", MemAddr, 16'h0002); chk1("s_v2", InstValid, 1'b1);
    chk16("s_pc0", InstPC, 16'h0000); chk16("s_out0", InstOut, 16'hA5A5);
    tick(); chk16("s_addr3", MemAddr, 16'h0003); chk16("s_pc1", InstPC, 16'h0001); chk16("s_out1", InstOut, 16'hA5A4);
    tick(); chk16("s_pc2", InstPC, 16'h0002); chk16("s_out2", InstOut, 16'hA5A7);
    tick(); chk16("s_pc3", InstPC, 16'h0003); chk16("s_out3", InstOut, 16'hA5A6);

    // Credit limit with Fetch stalled
    InstReady = 1'b0;
    do_reset();
    repeat (8) tick();
    chk1("c_rd_idle", MemRead, 1'b0); chk16("c_acc4", 16'(acc_cnt), 16'd4);
    chk1("c_valid", InstValid, 1'b1); chk16("c_pc0", InstPC, 16'h0000); chk16("c_out0", InstOut, 16'hA5A5);
    InstReady = 1'b1;
    tick();
    InstReady = 1'b0;
    #1 chk1("c_rd_one", MemRead, 1'b1); chk16("c_addr4", MemAddr, 16'h0004); chk16("c_pc1", InstPC, 16'h0001);
    repeat (3) tick();
    chk16("c_acc5", 16'(acc_cnt), 16'd5); chk1("c_rd_idle2", MemRead, 1'b0);
    chk16("c_pc1b", InstPC, 16'h0001); chk16("c_out1", InstOut, 16'hA5A4);

    // Memory stall on address 5
    MemWaitreq = 1'b1; InstReady = 1'b1;
    tick(); chk1("w_rd0", MemRead, 1'b1); chk16("w_addr0", MemAddr, 16'h0005); chk16("w_pc2", InstPC, 16'h0002);
    tick(); chk1("w_rd1", MemRead, 1'b1); chk16("w_addr1", MemAddr, 16'h0005);
    tick(); chk1("w_rd2", MemRead, 1'b1); chk16("w_addr2", MemAddr, 16'h0005); chk16("w_acc", 16'(acc_cnt), 16'd5);
    tick(); MemWaitreq = 1'b0;
    #1 chk16("w_addr3", MemAddr, 16'h0005); chk1("w_empty", InstValid, 1'b0);
    tick(); chk16("w_addr6", MemAddr, 16'h0006); chk16("w_acc6", 16'(acc_cnt), 16'd6);

    // Redirect with two reads in flight and one queued (2-cycle memory)
    InstReady = 1'b0;
    do_reset();
    lat = 2;
    repeat (4) tick();
    chk1("r_v_pre", InstValid, 1'b1); chk16("r_pc_pre", InstPC, 16'h0000); chk16("r_addr_pre", MemAddr, 16'h0003);
    Redirect = 1'b1; RedirectAddr = 16'h0040;
    #1 chk1("r_v_redir", InstValid, 1'b0);
    tick(); Redirect = 1'b0;
    #1 chk16("r_addr40", MemAddr, 16'h0040); chk1("r_v7", InstValid, 1'b0);
    tick(); chk1("r_v8", InstValid, 1'b0);
    tick(); chk1("r_v9", InstValid, 1'b0);
    tick(); chk1("r_v10", InstValid, 1'b1); chk16("r_pc40", InstPC, 16'h0040); chk16("r_out40", InstOut, 16'hA5E5);

    // Redirect while the request on address 7 is stalled
    InstReady = 1'b1;
    do_reset();
    lat = 1;
    repeat (8) tick();
    MemWaitreq = 1'b1;
    #1 chk1("h_rd7", MemRead, 1'b1); chk16("h_addr7", MemAddr, 16'h0007);
    tick(); Redirect = 1'b1; RedirectAddr = 16'h0100;
    #1 chk1("h_v_redir", InstValid, 1'b0); chk16("h_addr7b", MemAddr, 16'h0007);
    tick(); Redirect = 1'b0;
    #1 chk1("h_rd_held", MemRead, 1'b1); chk16("h_addr7c", MemAddr, 16'h0007); chk16("h_acc7", 16'(acc_cnt), 16'd7);
    tick(); MemWaitreq = 1'b0;
    #1 chk16("h_addr7d", MemAddr, 16'h0007);
    tick(); chk16("h_addr100", MemAddr, 16'h0100); chk1("h_v14", InstValid, 1'b0); chk16("h_acc8", 16'(acc_cnt), 16'd8);
    tick(); chk1("h_drop7", InstValid, 1'b0);
    tick(); chk1("h_v16", InstValid, 1'b1); chk16("h_pc100", InstPC, 16'h0100); chk16("h_out100", InstOut, 16'hA4A5);

    // Redirect near the top of the address space
    Redirect = 1'b1; RedirectAddr = 16'hFFFE;
    #1 chk1("x_v_redir", InstValid, 1'b0);
    tick(); Redirect = 1'b0;
    #1 chk16("x_addrfffe", MemAddr, 16'hFFFE); chk1("x_v17", InstValid, 1'b0);
    tick(); chk16("x_addrffff", MemAddr, 16'hFFFF); chk1("x_v18", InstValid, 1'b0);
    tick(); chk16("x_addr0000", MemAddr, 16'h0000); chk1("x_v19", InstValid, 1'b1);
    chk16("x_pcfffe", InstPC, 16'hFFFE); chk16("x_outfffe", InstOut, 16'h5A5B);
    tick(); chk16("x_pcffff", InstPC, 16'hFFFF); chk16("x_outffff", InstOut, 16'h5A5A);
    tick(); chk16("x_pc0000", InstPC, 16'h0000); chk16("x_out0000", InstOut, 16'hA5A5);

    // Asynchronous reset in the middle of the burst
    #1 Reset_n = 1'b0;
    #1 chk_reset_vals("arst");
    Reset_n = 1'b1;
    tick(); chk1("a_rd0", MemRead, 1'b1); chk16("a_addr0", MemAddr, 16'h0000);
    tick(); chk16("a_addr1", MemAddr, 16'h0001);
    tick(); chk1("a_v", InstValid, 1'b1); chk16("a_pc0", InstPC, 16'h0000); chk16("a_out0", InstOut, 16'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
